// File: rtl/spi_fram_responder.sv
// SPI FRAM-style responder: WREN/RDSR/READ/WRITE over a synchronized
// CPOL=1/CPHA=1 link, backed by an internal byte memory.
module spi_fram_responder #(
   parameter int ADDRESS_WIDTH = 24,
   parameter int MEM_ADDR_BITS = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       spi_sck,
   input  logic       spi_ss,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       wel,
   output logic [2:0] state_out
);

   localparam int ADDR_BYTES = ADDRESS_WIDTH / 8;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_RDSR  = 8'h05;
   localparam logic [7:0] OP_WREN  = 8'h06;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      COMMAND    = 3'd1,
      ADDRESS    = 3'd2,
      WRITE_DATA = 3'd3,
      READ_DATA  = 3'd4,
      STATUS     = 3'd5,
      IGNORE     = 3'd6
   } state_t;

   state_t state, state_next;

   logic [1:0] sck_sync, ss_sync, mosi_sync;
   logic       sck_prev, ss_prev;
   logic [1:0] settle;
   logic       armed;
   logic [2:0] bit_cnt;
   logic [6:0] rx_shift;
   logic [7:0] rx_next, tx_shift, load_byte;
   logic [3:0] addr_cnt;
   logic [MEM_ADDR_BITS-1:0] ptr, ptr_shift;
   logic       rd_cmd, wr_txn, load_pending;
   logic       ss_low, sck_rise, sck_fall, ss_fall, ss_rise;
   logic       byte_done, addr_last, tx_active;
   logic       mem_we, set_wel, arm_write;

   logic [7:0] mem [0:2**MEM_ADDR_BITS-1];

   assign ss_low    = ~ss_sync[1];
   assign sck_rise  = ss_low & sck_sync[1] & ~sck_prev;
   assign sck_fall  = ss_low & ~sck_sync[1] & sck_prev;
   // A fall only counts once SS has been seen high since reset.
   assign ss_fall   = armed & ss_prev & ~ss_sync[1];
   assign ss_rise   = ~ss_prev & ss_sync[1];
   assign rx_next   = {rx_shift, mosi_sync[1]};
   assign byte_done = sck_rise & (bit_cnt == 3'd7);
   assign addr_last = (addr_cnt == 4'(ADDR_BYTES - 1));
   assign ptr_shift = MEM_ADDR_BITS'({ptr, rx_next});
   assign load_byte = (state == STATUS) ? {6'b0, wel, 1'b0} : mem[ptr];
   assign tx_active = (state_next == READ_DATA) ||
                      (state_next == STATUS);
   assign spi_miso  = ((state == READ_DATA) || (state == STATUS))
                      ? tx_shift[7] : 1'b1;
   assign state_out = state;

   always_comb begin
      state_next = state;
      set_wel    = 1'b0;
      arm_write  = 1'b0;
      mem_we     = 1'b0;
      unique case (state)
         IDLE: if (ss_fall) state_next = COMMAND;
         COMMAND: begin
            if (byte_done) begin
               unique case (1'b1)
                  rx_next == OP_WREN: begin
                     state_next = IGNORE;
                     set_wel    = 1'b1;
                  end
                  rx_next == OP_RDSR: state_next = STATUS;
                  rx_next == OP_READ: state_next = ADDRESS;
                  (rx_next == OP_WRITE) && wel: begin
                     state_next = ADDRESS;
                     arm_write  = 1'b1;
                  end
                  default: state_next = IGNORE;
               endcase
            end
         end
         ADDRESS: begin
            if (byte_done && addr_last)
               state_next = rd_cmd ? READ_DATA : WRITE_DATA;
         end
         WRITE_DATA: mem_we = byte_done;
         default: ;
      endcase
      if (ss_rise) begin
         state_next = IDLE;
         set_wel    = 1'b0;
         arm_write  = 1'b0;
         mem_we     = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= IDLE;
         sck_sync     <= 2'b11;
         ss_sync      <= 2'b11;
         mosi_sync    <= 2'b00;
         sck_prev     <= 1'b1;
         ss_prev      <= 1'b1;
         settle       <= 2'b00;
         armed        <= 1'b0;
         bit_cnt      <= 3'd0;
         rx_shift     <= 7'd0;
         tx_shift     <= 8'hFF;
         addr_cnt     <= 4'd0;
         ptr          <= '0;
         rd_cmd       <= 1'b0;
         wr_txn       <= 1'b0;
         load_pending <= 1'b0;
         wel          <= 1'b0;
      end else begin
         state     <= state_next;
         sck_sync  <= {sck_sync[0], spi_sck};
         ss_sync   <= {ss_sync[0], spi_ss};
         mosi_sync <= {mosi_sync[0], spi_mosi};
         sck_prev  <= sck_sync[1];
         ss_prev   <= ss_sync[1];
         settle    <= {settle[0], 1'b1};
         armed     <= armed | (settle[1] & ss_sync[1]);

         if (ss_sync[1])    bit_cnt <= 3'd0;
         else if (sck_rise) bit_cnt <= bit_cnt + 3'd1;
         if (sck_rise) rx_shift <= rx_next[6:0];

         if (state == COMMAND && byte_done)
            rd_cmd <= (rx_next == OP_READ);

         if (set_wel)               wel <= 1'b1;
         else if (ss_rise && wr_txn) wel <= 1'b0;

         if (ss_rise)        wr_txn <= 1'b0;
         else if (arm_write) wr_txn <= 1'b1;

         if (state != ADDRESS) addr_cnt <= 4'd0;
         else if (byte_done)   addr_cnt <= addr_cnt + 4'd1;

         if (state == ADDRESS && byte_done)
            ptr <= ptr_shift;
         else if (mem_we)
            ptr <= ptr + 1'b1;
         else if (state == READ_DATA && sck_fall && load_pending)
            ptr <= ptr + 1'b1;

         if (!tx_active)     load_pending <= 1'b0;
         else if (byte_done) load_pending <= 1'b1;
         else if (sck_fall)  load_pending <= 1'b0;

         if (!tx_active)
            tx_shift <= 8'hFF;
         else if (sck_fall)
            tx_shift <= load_pending ? load_byte
                                     : {tx_shift[6:0], 1'b1};
      end
   end

   // No reset on the array; a write cycle coinciding with reset is dropped.
   always_ff @(posedge clock) begin
      if (reset && mem_we) mem[ptr] <= rx_next;
   end

endmodule

// File: tb/tb_spi_fram_responder.sv
// Scoreboard bench for spi_fram_responder: master-side MISO bytes
// are checked against queued expectations by an independent monitor.
module tb_spi_fram_responder;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       spi_sck = 1'b1;
   logic       spi_ss = 1'b1;
   logic       spi_mosi = 1'b0;
   logic       spi_miso;
   logic       wel;
   logic [2:0] state_out;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_q[$];
   logic [7:0] tq[$];
   logic [7:0] eq[$];

   always #5 clock = ~clock;

   spi_fram_responder #(
      .ADDRESS_WIDTH(24),
      .MEM_ADDR_BITS(10)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .spi_sck  (spi_sck),
      .spi_ss   (spi_ss),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .wel      (wel),
      .state_out(state_out)
   );

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h", nm, act, exp);
      end
   endtask

   task automatic clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         spi_sck  = 1'b0;
         spi_mosi = b[7-i];
         clk(4);
         spi_sck  = 1'b1;
         clk(4);
      end
   endtask

   task automatic ss_low();
      spi_ss = 1'b0;
      clk(4);
   endtask

   task automatic ss_high();
      clk(2);
      spi_ss = 1'b1;
      clk(8);
   endtask

   task automatic xfer();
      ss_low();
      foreach (tq[i]) begin
         exp_q.push_back(eq[i]);
         send_bits(tq[i], 8);
      end
      ss_high();
   endtask

   task automatic wren();
      tq = '{8'h06};
      eq = '{8'hFF};
      xfer();
   endtask

   // Master-side receiver: shifts MISO on each SCK rise while selected.
   initial begin : monitor
      logic [7:0] sh;
      int nb;
      sh = 8'h00;
      nb = 0;
      forever begin
         @(posedge spi_sck or posedge spi_ss);
         if (spi_ss) begin
            nb = 0;
         end else begin
            sh = {sh[6:0], spi_miso};
            nb++;
            if (nb == 8) begin
               nb = 0;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL miso_unexpected: got %02h expected none", sh);
               end else begin
                  chk("miso_byte", sh, exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      reset = 1'b0;
      clk(4);
      chk("rst_state", {5'b0, state_out}, 8'h00);
      chk("rst_wel", {7'b0, wel}, 8'h00);
      chk("rst_miso", {7'b0, spi_miso}, 8'h01);
      reset = 1'b1;
      clk(6);

      wren();
      chk("wel_after_wren", {7'b0, wel}, 8'h01);
      tq = '{8'h02, 8'h00, 8'h00, 8'h10, 8'hA5, 8'h5A};
      eq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      xfer();
      chk("wel_after_write", {7'b0, wel}, 8'h00);

      tq = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
      eq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA5, 8'h5A};
      xfer();

      wren();
      tq = '{8'h02, 8'h00, 8'h00, 8'h20, 8'h3C};
      eq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      xfer();
      tq = '{8'h02, 8'h00, 8'h00, 8'h20, 8'hC3};
      xfer();
      chk("wel_nowrite", {7'b0, wel}, 8'h00);
      tq = '{8'h03, 8'h00, 8'h00, 8'h20, 8'h00};
      eq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h3C};
      xfer();

      wren();
      tq = '{8'h05, 8'hFF, 8'hFF};
      eq = '{8'hFF, 8'h02, 8'h02};
      xfer();
      tq = '{8'h05, 8'hFF};
      eq = '{8'hFF, 8'h02};
      xfer();
      tq = '{8'h02, 8'h00, 8'h00, 8'h40};
      eq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      xfer();
      chk("wel_cleared_noData", {7'b0, wel}, 8'h00);
      tq = '{8'h05, 8'hFF};
      eq = '{8'hFF, 8'h00};
      xfer();

      wren();
      tq = '{8'h02, 8'h00, 8'h03, 8'hFF, 8'h11, 8'h22};
      eq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      xfer();
      tq = '{8'h03, 8'h00, 8'h03, 8'hFF, 8'h00, 8'h00};
      eq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h11, 8'h22};
      xfer();
      tq = '{8'h03, 8'hAB, 8'hCF, 8'hFF, 8'h00};
      eq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h11};
      xfer();
      tq = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
      eq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h22};
      xfer();

      wren();
      tq = '{8'h02, 8'h00, 8'h00, 8'h50, 8'h77};
      eq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      xfer();
      wren();
      ss_low();
      tq = '{8'h02, 8'h00, 8'h00, 8'h50};
      foreach (tq[i]) begin
         exp_q.push_back(8'hFF);
         send_bits(tq[i], 8);
      end
      send_bits(8'h88, 4);
      ss_high();
      chk("partial_state", {5'b0, state_out}, 8'h00);
      chk("partial_miso", {7'b0, spi_miso}, 8'h01);
      chk("partial_wel", {7'b0, wel}, 8'h00);

      wren();
      ss_low();
      foreach (tq[i]) begin
         exp_q.push_back(8'hFF);
         send_bits(tq[i], 8);
      end
      send_bits(8'h99, 4);
      reset = 1'b0;
      clk(3);
      chk("midrst_state", {5'b0, state_out}, 8'h00);
      chk("midrst_miso", {7'b0, spi_miso}, 8'h01);
      chk("midrst_wel", {7'b0, wel}, 8'h00);
      reset = 1'b1;
      clk(2);
      exp_q.push_back(8'hFF);
      send_bits(8'h99, 4);
      exp_q.push_back(8'hFF);
      send_bits(8'hAA, 8);
      chk("postrst_state", {5'b0, state_out}, 8'h00);
      ss_high();

      tq = '{8'h03, 8'h00, 8'h00, 8'h50, 8'h00};
      eq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h77};
      xfer();
      chk("final_wel", {7'b0, wel}, 8'h00);

      clk(20);
      chk("scoreboard_drain", 8'(exp_q.size()), 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_fram_responder.md
SPI_FRAM_RESPONDER -- requirements
Module: spi_fram_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 24, giving the number of address bits received on the wire (3 bytes).
REQ-002 SHALL have parameter MEM_ADDR_BITS, default 10, giving the internal byte-memory depth 2**MEM_ADDR_BITS.
REQ-003 SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port spi_sck, input, 1 bit: serial clock from the master; idles high.
REQ-006 SHALL have port spi_ss, input, 1 bit: active-low slave select.
REQ-007 SHALL have port spi_mosi, input, 1 bit: master-to-slave data, MSB first.
REQ-008 SHALL have port spi_miso, output, 1 bit: slave-to-master data, MSB first.
REQ-009 SHALL have port wel, output, 1 bit: write-enable latch.
REQ-010 SHALL have port state_out, output, 3 bits: current FSM state, for debug.

Function
REQ-011 SHALL pass spi_sck, spi_ss and spi_mosi through 2-flop synchronizers, then detect SCK rise and fall from the synchronized values; clock SHALL be >= 8x the SCK frequency.
REQ-012 SHALL sample MOSI on each synchronized SCK rise and update MISO on each synchronized SCK fall (CPOL=1, CPHA=1).
REQ-013 SHALL use a 3-bit bit counter that clears while SS is high and wraps 7->0; a byte completes on the 8th rise.
REQ-014 SHALL use FSM states IDLE, COMMAND, ADDRESS, WRITE_DATA, READ_DATA, STATUS and IGNORE.
REQ-015 SHALL go IDLE->COMMAND on the synchronized SS fall.
REQ-016 SHALL, on command-byte completion, decode the opcode: 0x06 -> IGNORE and set wel; 0x05 -> STATUS; 0x03 -> ADDRESS (read); 0x02 with wel=1 -> ADDRESS (write); 0x02 with wel=0 -> IGNORE; any other opcode -> IGNORE.
REQ-017 SHALL, in ADDRESS, shift 3 bytes MSB first into a 24-bit register, keep the low MEM_ADDR_BITS as the pointer, and then enter WRITE_DATA or READ_DATA.
REQ-018 SHALL, in WRITE_DATA, write mem[pointer] on each completed byte, then increment the pointer modulo 2**MEM_ADDR_BITS.
REQ-019 SHALL, in READ_DATA, load mem[pointer] into the output shifter on the SCK fall that follows byte completion, so bit7 is on MISO before the next rise; the pointer increments per byte and wraps.
REQ-020 SHALL, in STATUS, output the byte {6'b0, wel, 1'b0}, repeated for every byte while SS stays low.
REQ-021 SHALL drive spi_miso to 1 in IDLE, COMMAND, ADDRESS, WRITE_DATA and IGNORE.
REQ-022 SHALL, on the synchronized SS rise, return to IDLE from any state and clear the bit counter; a partial byte SHALL be discarded with no memory write.
REQ-023 SHALL clear wel on the SS rise that ends a 0x02 transaction in which wel was set, whether or not any byte completed.
REQ-024 SHALL make a 0x06 opcode set wel only when the full command byte completed.
REQ-025 SHALL ignore SCK edges while SS is high.
REQ-026 SHALL keep memory contents undefined at power-up and SHALL NOT clear memory on reset.

Reset
REQ-027 SHALL, while reset=0 at a clock edge, set state IDLE, wel=0, spi_miso=1, bit counter 0, pointer 0 and synchronizers high (SCK/SS) or 0 (MOSI).
REQ-028 SHALL, on reset asserted mid-transaction, abort the transaction with no further memory write, and after release wait for a fresh SS fall.

Verification
REQ-029 Scenario: 06 (SS cycle), 02 00 00 10 A5 5A -> mem[0x010]=A5, mem[0x011]=5A; wel=0 after SS rise.
REQ-030 Scenario: 03 00 00 10 then 2 dummy bytes -> MISO returns A5, 5A.
REQ-031 Scenario: 02 00 00 20 C3 with wel=0 -> mem[0x020] unchanged; MISO stays 1.
REQ-032 Scenario: 06, then 05 FF -> MISO byte 02; after a write, 05 -> 00.
REQ-033 Scenario: write 11 22 at 0x0003FF -> mem[0x3FF]=11, mem[0x000]=22 (wrap).
REQ-034 Scenario: SS rises after 4 bits of a data byte, or reset=0 mid-byte -> no memory write; state IDLE; spi_miso=1.
